// File: rtl/mem_store_queue_fwd.sv
// Store queue between the core bus and the memory-mapped BRAMs: buffers writes in
// FIFO order, drains them on canWrite, and forwards queued data to core reads.
module mem_store_queue_fwd #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 16,
  parameter int DEPTH      = 128,
  parameter int EDGE_WRITE = 1,
  parameter int AFULL_LVL  = DEPTH - 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     writeEn,
  input  logic [DATA_W-1:0]        dataIn,
  input  logic [ADDR_W-1:0]        addrIn,
  input  logic                     canWrite,
  output logic [DATA_W-1:0]        dataOut,
  output logic [ADDR_W-1:0]        addrOut,
  output logic                     dataValid,
  output logic                     full,
  output logic                     almostFull,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic [ADDR_W-1:0]        lookupAddr,
  output logic                     lookupHit,
  output logic [DATA_W-1:0]        lookupData
);

  localparam int  PTR_W     = $clog2(DEPTH);
  localparam int  CNT_W     = PTR_W + 1;
  localparam bit  EDGE_MODE = (EDGE_WRITE != 0);

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DEPTH-1:0]  valid;

  logic [PTR_W-1:0]  write_index;
  logic [PTR_W-1:0]  read_index;
  logic [PTR_W-1:0]  fwd_index;
  logic              last_write_en;

  logic              push_req;
  logic              push_ok;
  logic              pop;

  // In edge mode a held strobe only counts once; lastWriteEn clears on reset so a
  // strobe held through reset release still produces one push.
  assign push_req = writeEn & ~(EDGE_MODE & last_write_en);
  assign push_ok  = push_req & ~full;
  assign pop      = canWrite & ~empty;

  // Status flags come from the occupancy counter, never from pointer comparison.
  assign empty      = (count == '0);
  assign full       = (count == CNT_W'(DEPTH));
  assign almostFull = (count >= CNT_W'(AFULL_LVL));

  assign dataValid = pop;
  assign dataOut   = mem_data[read_index];
  assign addrOut   = mem_addr[read_index];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_index   <= '0;
      read_index    <= '0;
      count         <= '0;
      valid         <= '0;
      overflow      <= 1'b0;
      last_write_en <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update reading
      // start-of-cycle values, so the push and pop paths never see each other.
      last_write_en <= writeEn;

      if (push_ok) begin
        write_index        <= write_index + PTR_W'(1);
        valid[write_index] <= 1'b1;
      end

      // Push and pop never target the same slot: that would need the queue to be
      // both empty (no pop) and full (no push).
      if (pop) begin
        read_index        <= read_index + PTR_W'(1);
        valid[read_index] <= 1'b0;
      end

      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // A push against a full queue is dropped even if a pop frees a slot this cycle.
      if (push_req && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // NOTE: storage has no reset; the valid bits and occupancy alone decide what is
  // live, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_data[write_index] <= dataIn;
      mem_addr[write_index] <= addrIn;
    end
  end

  // Scan from oldest to youngest so the last match (youngest) overrides earlier ones.
  // The entry being pushed is not yet valid, the one being popped still is.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a
    // value unassigned and no latch is inferred.
    lookupHit  = 1'b0;
    lookupData = '0;
    fwd_index  = read_index;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_index = read_index + PTR_W'(i);
      if (valid[fwd_index] && (mem_addr[fwd_index] == lookupAddr)) begin
        lookupHit  = 1'b1;
        lookupData = mem_data[fwd_index];
      end
    end
  end

endmodule

// File: tb/tb_mem_store_queue_fwd.sv
// Directed bench for mem_store_queue_fwd: an edge-triggered and a level-triggered
// DEPTH=4 instance driven side by side through a linear sequence of steps.
module tb_mem_store_queue_fwd;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  // Edge-triggered instance signals
  logic        e_writeEn, e_canWrite;
  logic [7:0]  e_dataIn, e_dataOut, e_lookupData;
  logic [15:0] e_addrIn, e_addrOut, e_lookupAddr;
  logic        e_dataValid, e_full, e_almostFull, e_empty, e_overflow, e_lookupHit;
  logic [2:0]  e_count;

  // Level-triggered instance signals
  logic        l_writeEn, l_canWrite;
  logic [7:0]  l_dataIn, l_dataOut, l_lookupData;
  logic [15:0] l_addrIn, l_addrOut, l_lookupAddr;
  logic        l_dataValid, l_full, l_almostFull, l_empty, l_overflow, l_lookupHit;
  logic [2:0]  l_count;

  mem_store_queue_fwd #(
    .DATA_W(8), .ADDR_W(16), .DEPTH(4), .EDGE_WRITE(1), .AFULL_LVL(3)
  ) u_edge (
    .clk(clk), .rst(rst), .writeEn(e_writeEn), .dataIn(e_dataIn), .addrIn(e_addrIn),
    .canWrite(e_canWrite), .dataOut(e_dataOut), .addrOut(e_addrOut),
    .dataValid(e_dataValid), .full(e_full), .almostFull(e_almostFull), .empty(e_empty),
    .count(e_count), .overflow(e_overflow), .lookupAddr(e_lookupAddr),
    .lookupHit(e_lookupHit), .lookupData(e_lookupData)
  );

  mem_store_queue_fwd #(
    .DATA_W(8), .ADDR_W(16), .DEPTH(4), .EDGE_WRITE(0), .AFULL_LVL(3)
  ) u_level (
    .clk(clk), .rst(rst), .writeEn(l_writeEn), .dataIn(l_dataIn), .addrIn(l_addrIn),
    .canWrite(l_canWrite), .dataOut(l_dataOut), .addrOut(l_addrOut),
    .dataValid(l_dataValid), .full(l_full), .almostFull(l_almostFull), .empty(l_empty),
    .count(l_count), .overflow(l_overflow), .lookupAddr(l_lookupAddr),
    .lookupHit(l_lookupHit), .lookupData(l_lookupData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one full cycle; inputs change and outputs are sampled at the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic push_e(input logic [7:0] d, input logic [15:0] a);
    e_dataIn  = d;
    e_addrIn  = a;
    e_writeEn = 1'b1;
    cyc();
    e_writeEn = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b0;
    e_writeEn = 1'b0; e_canWrite = 1'b0; e_dataIn = '0; e_addrIn = '0; e_lookupAddr = '0;
    l_writeEn = 1'b0; l_canWrite = 1'b0; l_dataIn = '0; l_addrIn = '0; l_lookupAddr = '0;
    cyc();
    cyc();

    // Reset state
    check("rst_empty",      32'(e_empty),      32'd1);
    check("rst_full",       32'(e_full),       32'd0);
    check("rst_afull",      32'(e_almostFull), 32'd0);
    check("rst_dvalid",     32'(e_dataValid),  32'd0);
    check("rst_hit",        32'(e_lookupHit),  32'd0);
    check("rst_ldata",      32'(e_lookupData), 32'd0);
    check("rst_count",      32'(e_count),      32'd0);
    check("rst_overflow",   32'(e_overflow),   32'd0);
    check("rst_l_empty",    32'(l_empty),      32'd1);
    rst = 1'b1;
    cyc();

    // Basic FIFO order through the edge instance
    push_e(8'h11, 16'h2000);
    push_e(8'h22, 16'h2001);
    check("fifo_count2",    32'(e_count),      32'd2);
    check("fifo_not_empty", 32'(e_empty),      32'd0);
    check("fifo_afull_lo",  32'(e_almostFull), 32'd0);
    e_canWrite = 1'b1;
    #1;
    check("fifo_dv0",       32'(e_dataValid),  32'd1);
    check("fifo_data0",     32'(e_dataOut),    32'h11);
    check("fifo_addr0",     32'(e_addrOut),    32'h2000);
    cyc();
    check("fifo_dv1",       32'(e_dataValid),  32'd1);
    check("fifo_data1",     32'(e_dataOut),    32'h22);
    check("fifo_addr1",     32'(e_addrOut),    32'h2001);
    cyc();
    check("fifo_empty",     32'(e_empty),      32'd1);
    check("fifo_dv_off",    32'(e_dataValid),  32'd0);
    check("fifo_count0",    32'(e_count),      32'd0);
    e_canWrite = 1'b0;

    // Held strobe: one push in edge mode, one per cycle in level mode
    e_dataIn = 8'h33; e_addrIn = 16'h2100; e_writeEn = 1'b1;
    l_dataIn = 8'h44; l_addrIn = 16'h4000; l_writeEn = 1'b1;
    repeat (4) cyc();
    check("lvl_count4",     32'(l_count),      32'd4);
    check("lvl_full",       32'(l_full),       32'd1);
    check("lvl_afull",      32'(l_almostFull), 32'd1);
    check("lvl_no_ovf_yet", 32'(l_overflow),   32'd0);
    cyc();
    e_writeEn = 1'b0;
    l_writeEn = 1'b0;
    check("edge_held_cnt1", 32'(e_count),      32'd1);
    check("lvl_count_hold", 32'(l_count),      32'd4);
    check("lvl_overflow",   32'(l_overflow),   32'd1);
    e_canWrite = 1'b1;
    l_canWrite = 1'b1;
    cyc();
    e_canWrite = 1'b0;
    repeat (3) cyc();
    l_canWrite = 1'b0;
    check("edge_drained",   32'(e_empty),      32'd1);
    check("lvl_drained",    32'(l_empty),      32'd1);

    // Full queue: push and pop in the same cycle -> pop happens, push dropped
    for (int i = 1; i <= 4; i++) push_e(8'(i), 16'h3000 + 16'(i));
    check("full_full",      32'(e_full),       32'd1);
    check("full_ovf_pre",   32'(e_overflow),   32'd0);
    e_dataIn = 8'h99; e_addrIn = 16'h3999; e_writeEn = 1'b1; e_canWrite = 1'b1;
    #1;
    check("full_dv",        32'(e_dataValid),  32'd1);
    check("full_head",      32'(e_dataOut),    32'h01);
    cyc();
    e_writeEn = 1'b0; e_canWrite = 1'b0;
    check("full_count3",    32'(e_count),      32'd3);
    check("full_ovf_set",   32'(e_overflow),   32'd1);
    check("full_not_full",  32'(e_full),       32'd0);
    e_canWrite = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      #1;
      check("full_drain",   32'(e_dataOut),    32'(i));
      cyc();
    end
    e_canWrite = 1'b0;
    check("full_empty",     32'(e_empty),      32'd1);

    // Store-to-load forwarding
    push_e(8'hAA, 16'h0100);
    push_e(8'hBB, 16'h0100);
    e_lookupAddr = 16'h0100;
    #1;
    check("fwd_hit",        32'(e_lookupHit),  32'd1);
    check("fwd_youngest",   32'(e_lookupData), 32'hBB);
    e_lookupAddr = 16'h0101;
    #1;
    check("fwd_miss",       32'(e_lookupHit),  32'd0);
    check("fwd_miss_data",  32'(e_lookupData), 32'd0);
    e_dataIn = 8'hCC; e_addrIn = 16'h0200; e_writeEn = 1'b1; e_lookupAddr = 16'h0200;
    #1;
    check("fwd_push_hidden", 32'(e_lookupHit), 32'd0);
    cyc();
    e_writeEn = 1'b0;
    #1;
    check("fwd_pushed_hit", 32'(e_lookupHit),  32'd1);
    check("fwd_pushed_dat", 32'(e_lookupData), 32'hCC);
    e_lookupAddr = 16'h0100; e_canWrite = 1'b1;
    #1;
    check("fwd_head_aa",    32'(e_dataOut),    32'hAA);
    check("fwd_pop_aa_dat", 32'(e_lookupData), 32'hBB);
    cyc();
    check("fwd_head_bb",    32'(e_dataOut),    32'hBB);
    check("fwd_popping_hit", 32'(e_lookupHit), 32'd1);
    check("fwd_popping_dat", 32'(e_lookupData), 32'hBB);
    cyc();
    check("fwd_gone_hit",   32'(e_lookupHit),  32'd0);
    check("fwd_gone_data",  32'(e_lookupData), 32'd0);
    cyc();
    e_canWrite = 1'b0;
    check("fwd_empty",      32'(e_empty),      32'd1);

    // Pointer wrap: simultaneous push/pop stream 0..9 through the level instance
    l_dataIn = 8'd0; l_addrIn = 16'h5000; l_writeEn = 1'b1;
    cyc();
    for (int i = 1; i <= 9; i++) begin
      l_dataIn = 8'(i);
      l_canWrite = 1'b1;
      #1;
      check("wrap_dv",      32'(l_dataValid),  32'd1);
      check("wrap_data",    32'(l_dataOut),    32'(i - 1));
      cyc();
      check("wrap_count",   32'(l_count),      32'd1);
    end
    l_writeEn = 1'b0;
    #1;
    check("wrap_last",      32'(l_dataOut),    32'd9);
    cyc();
    l_canWrite = 1'b0;
    check("wrap_empty",     32'(l_empty),      32'd1);

    // Reset mid-drain, with the edge strobe held across release
    l_dataIn = 8'h61; l_addrIn = 16'h6000; l_writeEn = 1'b1;
    repeat (3) cyc();
    l_writeEn = 1'b0;
    check("mid_count3",     32'(l_count),      32'd3);
    l_canWrite = 1'b1;
    e_dataIn = 8'h77; e_addrIn = 16'h7000; e_writeEn = 1'b1;
    #1;
    check("mid_dv",         32'(l_dataValid),  32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_empty",  32'(l_empty),      32'd1);
    check("mid_rst_dv",     32'(l_dataValid),  32'd0);
    check("mid_rst_count",  32'(l_count),      32'd0);
    check("mid_rst_ovf",    32'(l_overflow),   32'd0);
    cyc();
    l_canWrite = 1'b0;
    rst = 1'b1;
    cyc();
    check("held_rel_push",  32'(e_count),      32'd1);
    cyc();
    check("held_rel_once",  32'(e_count),      32'd1);
    e_writeEn = 1'b0;
    l_dataIn = 8'h5A; l_addrIn = 16'h6100; l_writeEn = 1'b1;
    cyc();
    l_writeEn = 1'b0;
    l_canWrite = 1'b1;
    #1;
    check("post_rst_dv",    32'(l_dataValid),  32'd1);
    check("post_rst_data",  32'(l_dataOut),    32'h5A);
    cyc();
    l_canWrite = 1'b0;
    check("post_rst_empty", 32'(l_empty),      32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
